// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: walks mac_len steps over num_win windows, issuing
// IFM/weight buffer reads and presenting operands to the PE array.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   start, mac_len, num_win       pass request and geometry (latched)
//   ifm_base, wgt_base            buffer base addresses (latched)
//   mem_rd, ifm_addr, wgt_addr    buffer read strobe and addresses
//   ifm_rdata, wgt_rdata          read data, one cycle after mem_rd
//   IFM, Weight                   operands, two cycles after the read
//   PE_en, PE_finish              per-lane window start / end pulses
//   busy, done                    pass active / pass-complete pulse
module pe_array_sequencer #(
    parameter int NUM_OF_PE = 256,
    parameter int ADDR_W    = 12,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [7:0]             mac_len,
    input  logic [CNT_W-1:0]       num_win,
    input  logic [ADDR_W-1:0]      ifm_base,
    input  logic [ADDR_W-1:0]      wgt_base,
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      ifm_addr,
    output logic [ADDR_W-1:0]      wgt_addr,
    input  logic [NUM_OF_PE*8-1:0] ifm_rdata,
    input  logic [7:0]             wgt_rdata,
    output logic [NUM_OF_PE*8-1:0] IFM,
    output logic [7:0]             Weight,
    output logic [NUM_OF_PE-1:0]   PE_en,
    output logic [NUM_OF_PE-1:0]   PE_finish,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_t;

    localparam logic [CNT_W-1:0]  W_ONE = 1;
    localparam logic [ADDR_W-1:0] A_ONE = 1;

    state_t                 state_q;
    logic [7:0]             ml_q;
    logic [7:0]             m_q;
    logic [CNT_W-1:0]       nw_q;
    logic [CNT_W-1:0]       w_q;
    logic [ADDR_W-1:0]      ifm_base_q;
    logic [ADDR_W-1:0]      wgt_base_q;
    logic [ADDR_W-1:0]      ifm_addr_q;
    logic [ADDR_W-1:0]      wgt_addr_q;
    logic                   rd_q;
    logic                   first_q;
    logic                   last_q;
    logic                   done_q;
    logic                   v1_q;
    logic                   f1_q;
    logic                   l1_q;
    logic                   l2_q;
    logic                   en_q;
    logic                   fin_q;
    logic [NUM_OF_PE*8-1:0] ifm_q;
    logic [7:0]             wgt_q;

    logic [CNT_W-1:0]       w_d;
    logic [CNT_W+7:0]       off_d;
    logic                   last_step;

    // Offset of the next window, formed at full product width and
    // only then truncated to the address width.
    always_comb begin
        w_d       = w_q + W_ONE;
        off_d     = {8'b0, w_d} * {{CNT_W{1'b0}}, ml_q};
        last_step = (m_q == ml_q - 8'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ml_q       <= '0;
            m_q        <= '0;
            nw_q       <= '0;
            w_q        <= '0;
            ifm_base_q <= '0;
            wgt_base_q <= '0;
            ifm_addr_q <= '0;
            wgt_addr_q <= '0;
            rd_q       <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            v1_q       <= 1'b0;
            f1_q       <= 1'b0;
            l1_q       <= 1'b0;
            l2_q       <= 1'b0;
            en_q       <= 1'b0;
            fin_q      <= 1'b0;
            ifm_q      <= '0;
            wgt_q      <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (mac_len == 8'd0 || num_win == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q    <= RUN;
                            ml_q       <= mac_len;
                            nw_q       <= num_win;
                            ifm_base_q <= ifm_base;
                            wgt_base_q <= wgt_base;
                            w_q        <= '0;
                            m_q        <= '0;
                            rd_q       <= 1'b1;
                            first_q    <= 1'b1;
                            last_q     <= (mac_len == 8'd1);
                            ifm_addr_q <= ifm_base;
                            wgt_addr_q <= wgt_base;
                        end
                    end
                end
                RUN: begin
                    if (last_step) begin
                        state_q <= GAP;
                    end else begin
                        m_q        <= m_q + 8'd1;
                        rd_q       <= 1'b1;
                        last_q     <= (m_q + 8'd2 == ml_q);
                        ifm_addr_q <= ifm_addr_q + A_ONE;
                        wgt_addr_q <= wgt_addr_q + A_ONE;
                    end
                end
                GAP: begin
                    if (w_q == nw_q - W_ONE) begin
                        state_q <= DRAIN;
                    end else begin
                        state_q    <= RUN;
                        w_q        <= w_d;
                        m_q        <= '0;
                        rd_q       <= 1'b1;
                        first_q    <= 1'b1;
                        last_q     <= (ml_q == 8'd1);
                        ifm_addr_q <= ifm_base_q + off_d[ADDR_W-1:0];
                        wgt_addr_q <= wgt_base_q;
                    end
                end
                DRAIN: begin
                    // Earlier windows finish before DRAIN begins, so any
                    // finish seen here belongs to the final window.
                    if (fin_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Read issue -> data returns -> operand registered -> finish.
            v1_q  <= rd_q;
            f1_q  <= first_q;
            l1_q  <= last_q;
            en_q  <= f1_q;
            l2_q  <= l1_q;
            fin_q <= l2_q;
            if (v1_q) begin
                ifm_q <= ifm_rdata;
                wgt_q <= wgt_rdata;
            end
        end
    end

    assign mem_rd    = rd_q;
    assign ifm_addr  = ifm_addr_q;
    assign wgt_addr  = wgt_addr_q;
    assign IFM       = ifm_q;
    assign Weight    = wgt_q;
    assign PE_en     = {NUM_OF_PE{en_q}};
    assign PE_finish = {NUM_OF_PE{fin_q}};
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// tb_pe_array_sequencer: scoreboard bench for pe_array_sequencer.
// Events expected per pass are queued from cycle arithmetic.
module tb_pe_array_sequencer;

    localparam int NP = 256;
    localparam int AW = 12;
    localparam int CW = 16;

    typedef struct {
        int            c;
        logic [AW-1:0] ia;
        logic [AW-1:0] wa;
    } rd_t;

    typedef struct {
        int              c;
        logic [NP*8-1:0] ifm;
        logic [7:0]      wgt;
    } pr_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [7:0]      mac_len = '0;
    logic [CW-1:0]   num_win = '0;
    logic [AW-1:0]   ifm_base = '0;
    logic [AW-1:0]   wgt_base = '0;
    logic            mem_rd;
    logic [AW-1:0]   ifm_addr;
    logic [AW-1:0]   wgt_addr;
    logic [NP*8-1:0] ifm_rdata = '0;
    logic [7:0]      wgt_rdata = '0;
    logic [NP*8-1:0] IFM;
    logic [7:0]      Weight;
    logic [NP-1:0]   PE_en;
    logic [NP-1:0]   PE_finish;
    logic            busy;
    logic            done;

    pe_array_sequencer #(.NUM_OF_PE(NP), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .mac_len(mac_len), .num_win(num_win),
        .ifm_base(ifm_base), .wgt_base(wgt_base),
        .mem_rd(mem_rd), .ifm_addr(ifm_addr), .wgt_addr(wgt_addr),
        .ifm_rdata(ifm_rdata), .wgt_rdata(wgt_rdata),
        .IFM(IFM), .Weight(Weight),
        .PE_en(PE_en), .PE_finish(PE_finish),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    rd_t rdq[$];
    pr_t prq[$];
    int  enq[$];
    int  finq[$];
    int  doneq[$];

    logic [NP*8-1:0] exp_ifm = '0;
    logic [7:0]      exp_wgt = '0;
    int              b_lo = 0;
    int              b_hi = 0;
    bit              mon_en = 1'b0;

    function automatic logic [NP*8-1:0] ifm_of(input logic [AW-1:0] a);
        logic [NP*8-1:0] r;
        for (int i = 0; i < NP; i++) r[i*8 +: 8] = a[7:0] + 8'(i);
        return r;
    endfunction

    // Buffer model: data derived from the address, one cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_rd) begin
            ifm_rdata <= ifm_of(ifm_addr);
            wgt_rdata <= wgt_addr[7:0];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h required %0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic ev(input string nm, input logic a, ref int q[$]);
        if (a) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL %s unexpected: got pulse at cycle %0d, required none",
                         nm, cyc);
            end else begin
                chk(nm, 64'(cyc), 64'(q.pop_front()));
            end
        end else if (q.size() > 0 && q[0] < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL %s missing: got none, required at cycle %0d",
                     nm, q.pop_front());
        end
    endtask

    always @(negedge clk) begin : monitor
        rd_t r;
        pr_t p;
        if (mon_en) begin
            if (mem_rd) begin
                if (rdq.size() == 0) begin
                    chk("unexpected_mem_rd", 1, 0);
                end else begin
                    r = rdq.pop_front();
                    chk("rd_cycle", 64'(cyc), 64'(r.c));
                    chk("ifm_addr", 64'(ifm_addr), 64'(r.ia));
                    chk("wgt_addr", 64'(wgt_addr), 64'(r.wa));
                end
            end else if (rdq.size() > 0 && rdq[0].c < cyc) begin
                r = rdq.pop_front();
                chk("missing_mem_rd", 64'(cyc), 64'(r.c));
            end
            if (prq.size() > 0 && prq[0].c <= cyc) begin
                p = prq.pop_front();
                exp_ifm = p.ifm;
                exp_wgt = p.wgt;
            end
            vectors++;
            if (IFM !== exp_ifm) begin
                miscompares++;
                $display("FAIL ifm @cyc %0d: got lane0 %0h required lane0 %0h",
                         cyc, IFM[7:0], exp_ifm[7:0]);
            end
            chk("weight", 64'(Weight), 64'(exp_wgt));
            chk("pe_en_uniform", 64'(PE_en == '0 || PE_en == '1), 1);
            chk("pe_fin_uniform", 64'(PE_finish == '0 || PE_finish == '1), 1);
            ev("pe_en", PE_en[0], enq);
            ev("pe_finish", PE_finish[0], finq);
            ev("done", done, doneq);
            chk("busy", 64'(busy), 64'(cyc >= b_lo && cyc < b_hi));
        end
    end

    // Reference: window w, step m is issued at t0+1+w*(mac_len+1)+m.
    task automatic model(input int t0, input int ml, input int nw,
                         input int ib, input int wb);
        rd_t r;
        pr_t p;
        int  ic;
        int  last_fin;
        if (ml == 0 || nw == 0) begin
            doneq.push_back(t0 + 1);
            b_lo = 0;
            b_hi = 0;
            return;
        end
        last_fin = 0;
        for (int w = 0; w < nw; w++) begin
            for (int m = 0; m < ml; m++) begin
                ic    = t0 + 1 + w * (ml + 1) + m;
                r.c   = ic;
                r.ia  = AW'(ib + w * ml + m);
                r.wa  = AW'(wb + m);
                rdq.push_back(r);
                p.c   = ic + 2;
                p.ifm = ifm_of(r.ia);
                p.wgt = r.wa[7:0];
                prq.push_back(p);
                if (m == 0) enq.push_back(ic + 2);
                if (m == ml - 1) begin
                    finq.push_back(ic + 3);
                    last_fin = ic + 3;
                end
            end
        end
        doneq.push_back(last_fin + 1);
        b_lo = t0 + 1;
        b_hi = last_fin + 1;
    endtask

    task automatic flush();
        rdq.delete();
        prq.delete();
        enq.delete();
        finq.delete();
        doneq.delete();
    endtask

    task automatic drain();
        int n = 0;
        while ((rdq.size() + prq.size() + enq.size() + finq.size()
                + doneq.size()) > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            chk("drain_timeout", 1, 0);
            flush();
        end
        @(negedge clk);
    endtask

    task automatic run_pass(input int ml, input int nw, input int ib,
                            input int wb, input bit ghost);
        @(negedge clk);
        start    = 1'b1;
        mac_len  = 8'(ml);
        num_win  = CW'(nw);
        ifm_base = AW'(ib);
        wgt_base = AW'(wb);
        model(cyc, ml, nw, ib, wb);
        @(negedge clk);
        start = 1'b0;
        if (ghost) begin
            start    = 1'b1;
            mac_len  = 8'($urandom_range(1, 40));
            num_win  = CW'($urandom_range(1, 9));
            ifm_base = AW'($urandom);
            wgt_base = AW'($urandom);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_mem_rd"}, 64'(mem_rd), 0);
        chk({tag, "_ifm_addr"}, 64'(ifm_addr), 0);
        chk({tag, "_wgt_addr"}, 64'(wgt_addr), 0);
        chk({tag, "_ifm_zero"}, 64'(IFM == '0), 1);
        chk({tag, "_weight"}, 64'(Weight), 0);
        chk({tag, "_pe_en"}, 64'(PE_en == '0), 1);
        chk({tag, "_pe_finish"}, 64'(PE_finish == '0), 1);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
    endtask

    initial begin
        #1;
        chk_zero_outputs("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        run_pass(27, 2, 0, 0, 1'b0);
        drain();
        run_pass(1, 3, 5, 9, 1'b0);
        drain();
        run_pass(27, 0, 3, 3, 1'b0);
        drain();
        run_pass(0, 4, 3, 3, 1'b0);
        drain();
        run_pass(27, 2, 'hFF0, 'hFF8, 1'b0);
        drain();
        run_pass(1, 2, 'hFFF, 'h7, 1'b1);
        drain();

        for (int k = 0; k < 14; k++) begin
            run_pass($urandom_range(1, 30), $urandom_range(1, 4),
                     $urandom_range(0, 4095), $urandom_range(0, 4095),
                     1'(k % 2));
            drain();
        end

        // Abandon a pass mid-window, with an ignored start pending.
        run_pass(10, 3, 'h100, 'h20, 1'b1);
        repeat (12) @(negedge clk);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        flush();
        exp_ifm = '0;
        exp_wgt = '0;
        b_lo    = 0;
        b_hi    = 0;
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (40) @(negedge clk);

        run_pass(3, 2, 'h40, 'h10, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_array_sequencer.md
PE_ARRAY_SEQUENCER -- requirements
Module: pe_array_sequencer

Interface
REQ-001 SHALL have parameter NUM_OF_PE, default 256: PE lanes, one IFM byte per lane.
REQ-002 SHALL have parameter ADDR_W, default 12: buffer address width.
REQ-003 SHALL have parameter CNT_W, default 16: window counter width.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: begin a layer pass; sampled only in IDLE.
REQ-007 SHALL have port mac_len, input, 8: MAC steps per window (e.g. 27 = 3x3x3); latched at start.
REQ-008 SHALL have port num_win, input, CNT_W: windows per pass; latched at start.
REQ-009 SHALL have ports ifm_base and wgt_base, input, ADDR_W each: buffer base addresses; latched at start.
REQ-010 SHALL have port mem_rd, output, 1: buffer read strobe.
REQ-011 SHALL have ports ifm_addr and wgt_addr, output, ADDR_W each: read addresses, valid when mem_rd=1.
REQ-012 SHALL have ports ifm_rdata, input, NUM_OF_PE*8, and wgt_rdata, input, 8: read data, one cycle after mem_rd.
REQ-013 SHALL have ports IFM, output, NUM_OF_PE*8, and Weight, output, 8: operands to the 256-PE conv array.
REQ-014 SHALL have ports PE_en and PE_finish, output, NUM_OF_PE each: all bits equal, window start/end pulses.
REQ-015 SHALL have ports busy, output, 1, and done, output, 1: pass active; one-cycle pass-complete pulse.

Function
REQ-016 SHALL implement states IDLE, RUN, GAP, DRAIN.
REQ-017 IDLE->RUN SHALL occur on start=1 with mac_len!=0 and num_win!=0; window index w=0, step m=0.
REQ-018 start with mac_len=0 or num_win=0 SHALL remain in IDLE, pulse done the next cycle, and emit no mem_rd, PE_en or PE_finish.
REQ-019 In RUN, each cycle SHALL assert mem_rd with ifm_addr=ifm_base+w*mac_len+m and wgt_addr=wgt_base+m, then increment m; addresses SHALL wrap modulo 2^ADDR_W.
REQ-020 After m=mac_len-1 issues, the FSM SHALL go to GAP for exactly one cycle with mem_rd=0, then return to RUN with w+1 and m=0, or go to DRAIN if w=num_win-1.
REQ-021 Read-to-present latency SHALL be 2 cycles: data read at issue cycle c SHALL be registered onto IFM/Weight and appear during cycle c+2.
REQ-022 PE_en SHALL be high for exactly the cycle in which step 0 of each window is presented.
REQ-023 PE_finish SHALL be high for exactly the cycle after step mac_len-1 of each window is presented, i.e. issue cycle of last step +3.
REQ-024 Consequently PE_finish of window w SHALL never coincide with PE_en of window w+1; window period SHALL be mac_len+1 cycles.
REQ-025 IFM and Weight SHALL hold their last values when no new data is presented.
REQ-026 DRAIN SHALL last until the final PE_finish cycle; done SHALL pulse in the following cycle, with the FSM entering IDLE in that same cycle.
REQ-027 busy SHALL be high in RUN, GAP and DRAIN, and low in IDLE.
REQ-028 start while busy=1 SHALL be ignored without altering the pass.
REQ-029 w*mac_len SHALL be computed at full width (CNT_W+8 bits) and then truncated to ADDR_W.
REQ-030 mac_len=1 SHALL assert PE_en and PE_finish on consecutive cycles per window, with a 2-cycle window period.

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE and zero the pipeline flags, and drive IFM, Weight, PE_en, PE_finish, mem_rd, addresses, busy and done all to 0.
REQ-032 Reset mid-pass SHALL abandon the pass; after release no PE_en, PE_finish or done SHALL appear until a new start.

Verification
REQ-033 mac_len=27, num_win=2, bases=0, start at cycle 0 -> mem_rd cycles 1-27 and 29-55; PE_en at cycles 3 and 31; PE_finish at cycles 30 and 58; done at 59.
REQ-034 Memory model returning data=address -> presented Weight sequence 0..26 repeats per window; IFM lane 0 of window 1 starts at 27.
REQ-035 mac_len=1, num_win=3 -> PE_en at cycles 3, 5, 7; PE_finish at cycles 4, 6, 8; done at 9.
REQ-036 num_win=0 at start -> done pulses next cycle; mem_rd, PE_en and PE_finish stay 0; busy stays 0.
REQ-037 ifm_base=0xFF0, mac_len=27 -> ifm_addr wraps 0xFFF->0x000 without error.
REQ-038 reset_n low mid-window, second start pulse during busy -> all outputs 0 immediately; ignored start produces no extra windows.
